uart_receiver: RTL
==================

// Module: uart_receiver
// PURPOSE
//  Standalone UART receive path (8N1, 8E1 with parity option) for the memory-mapped UART
//  at 0x10010000. Listens on the serial rx line driven by the peer transmitter (loopback tx
//  in bring-up). Deframes bytes and holds the last byte for the core. Raises read_ready
//  until the core reads uart_rw (read_ack). Reports framing and overrun errors for line_status.
// PARAMETERS
//  OVERSAMPLE  16  sample ticks per bit; mid-bit sample at tick OVERSAMPLE/2-1
//  SYNC_STAGES 2   rx metastability flops, reset value 1 (line idle)
// PORTS
//  clk            input   1   system clock
//  rst            input   1   asynchronous, active-low reset
//  rx             input   1   serial line, idle high, async to clk
//  baud_rate      input  32   bits per second, e.g. 115200
//  clk_frequency  input  32   clk Hz (software-writable register at 0x10010100)
//  read_ack       input   1   one-cycle pulse: core consumed rx_data
//  rx_data        output  8   last received byte, LSB first on line
//  outValid       output  1   one-cycle pulse when rx_data updates
//  read_ready     output  1   unread byte held
//  rx_busy        output  1   frame in progress (state != IDLE)
//  frame_error    output  1   stop bit of last frame sampled low
//  overrun        output  1   sticky: byte loaded while read_ready still set
// BEHAVIOUR
//  Async active-low reset: all outputs 0; sync flops 1; acc 0; state IDLE.
//  Tick gen: 36-bit acc; inc = baud_rate*OVERSAMPLE each clk.
//   If acc+inc >= clk_frequency: tick=1, acc <= acc+inc-clk_frequency; else acc <= acc+inc.
//   No divide.
//  Tick gen runs freely; acc is not cleared on start. Start-edge phase error <= 1 tick is
//  accepted.
//  FSM (all advances on tick only, except IDLE edge detect):
//   IDLE: armed only after synced rx seen 1. Falling edge -> START, samp_cnt<=0.
//   START: at samp_cnt==7, if rx==0 -> DATA, bit_cnt<=0, samp_cnt<=0.
//    If rx==1 (glitch) -> IDLE, no output.
//   DATA: sample at mid-bit, shift right into shreg[7]; after bit 7 -> PARITY (if enabled)
//    else STOP.
//   STOP: at mid-bit: rx_data<=shreg, outValid=1 for one clk, frame_error<=~rx,
//    read_ready<=1 -> IDLE (re-arm waits for rx==1, so a stuck-low line gives one error only).
//  read_ready/overrun updates:
//   Load with read_ready=1 and no read_ack in the same cycle: overrun<=1.
//   Load and read_ack in the same cycle: read_ready stays 1, no overrun.
//   read_ack with no load: read_ready<=0, overrun<=0.
//   frame_error is held until the next load.
//  Latency: outValid asserts 1 clk after the stop-bit mid-sample tick.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   Adds PARITY state after DATA; samples the even-parity bit at mid-bit.
//   Adds output parity_error (1 bit, reset 0), updated on each load:
//    ^{shreg,parity_bit} != 0.
//  UART_RX_PARITY_EN undefined:
//   No PARITY state; parity_error port absent; frame is exactly 10 bit times.
// STRUCTURE
//  uart_pkg:
//   typedef enum logic [2:0] {IDLE,START,DATA,PARITY,STOP} uart_rx_state_t;
//   localparam DATA_BITS=8, OVERSAMPLE=16.
//  Sub-module uart_baud_tick: accumulator tick generator; reusable by the transmitter.
// TESTING (clk_frequency=1_843_200, baud_rate=115200 -> 1 tick/clk, 16 clk/bit)
//  Send 0x55, then 0xA3: outValid pulses twice; rx_data=0x55 then 0xA3.
//   read_ready=1; frame_error=0.
//  Low glitch of 4 clk on idle rx: state returns IDLE; no outValid; rx_busy pulses only.
//  0x3C with stop bit forced 0: rx_data=0x3C, frame_error=1.
//   No second frame until rx returns to 1.
//  Two bytes, no read_ack: overrun=1, rx_data=2nd byte.
//   read_ack -> read_ready=0, overrun=0. Ack coincident with load -> no overrun.
//  rst low mid-DATA: outputs 0 at once; after release, next full 0x81 is received correctly.
//  UART_RX_PARITY_EN: 0x07 + parity 1 -> parity_error=0; parity 0 -> parity_error=1.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
//
// Purpose: receiver FSM state encoding, frame width and default oversampling ratio.
// Ports:   none (package).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - fractional accumulator producing oversample ticks
//
// Purpose: emits tick at an average rate of baud_rate*OVERSAMPLE per second from clk,
//          without a divider. The accumulator runs freely and is never realigned.
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-low reset
//   baud_rate      in   32-bit bits per second
//   clk_frequency  in   32-bit clk frequency in Hz
//   tick           out  one-clk oversample strobe (combinational from acc)
module uart_baud_tick #(
    parameter int OVERSAMPLE = 16,
    parameter int ACC_W      = 36
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] baud_rate,
    input  logic [31:0] clk_frequency,
    output logic        tick
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   freq_ext;

    always_comb begin
        inc      = ACC_W'(baud_rate) * ACC_W'(OVERSAMPLE);
        sum      = {1'b0, acc} + {1'b0, inc};
        freq_ext = (ACC_W + 1)'(clk_frequency);
        tick     = (sum >= freq_ext);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (tick) begin
            acc <= ACC_W'(sum - freq_ext);
        end else begin
            acc <= ACC_W'(sum);
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receive path (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
//
// Purpose: synchronises rx, deframes LSB-first bytes on oversample ticks, holds the last
//          byte for the core and reports framing / overrun (and parity) status.
// Configuration macro: UART_RX_PARITY_EN adds the even-parity bit and parity_error.
// Ports:
//   clk, rst       in   clock, asynchronous active-low reset
//   rx             in   serial line, idle high, asynchronous to clk
//   baud_rate      in   32-bit bits per second
//   clk_frequency  in   32-bit clk frequency in Hz
//   read_ack       in   one-clk pulse, core consumed rx_data
//   rx_data        out  last received byte
//   outValid       out  one-clk pulse when rx_data updates
//   read_ready     out  unread byte held
//   rx_busy        out  frame in progress
//   frame_error    out  stop bit of last frame sampled low
//   parity_error   out  parity of last frame wrong (UART_RX_PARITY_EN only)
//   overrun        out  sticky, byte loaded while previous still unread
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [31:0]          baud_rate,
    input  logic [31:0]          clk_frequency,
    input  logic                 read_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 outValid,
    output logic                 read_ready,
    output logic                 rx_busy,
    output logic                 frame_error,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 overrun
);

    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [SAMP_W-1:0] MID_CNT  = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] LAST_CNT = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic                   tick;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;

    uart_rx_state_t         state, state_next;
    logic [SAMP_W-1:0]      samp_cnt, samp_next;
    logic [BIT_W-1:0]       bit_cnt, bit_next;
    logic [DATA_BITS-1:0]   shreg, shreg_next;
    logic                   armed, armed_next;
    logic                   load;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit, par_next;
`endif

    uart_baud_tick #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk           (clk),
        .rst           (rst),
        .baud_rate     (baud_rate),
        .clk_frequency (clk_frequency),
        .tick          (tick)
    );

    // Sync chain resets to 1 so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s    = sync[SYNC_STAGES-1];
    assign rx_busy = (state != IDLE);

    // After START the counter restarts at the start-bit centre, so every later
    // centre sample falls on a full bit period (LAST_CNT).
    always_comb begin
        state_next = state;
        samp_next  = samp_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        armed_next = armed;
        load       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next   = par_bit;
`endif
        case (state)
            IDLE: begin
                // Only a high-to-low transition starts a frame; a line stuck low
                // after a framing error stays disarmed until it returns high.
                if (rx_s) begin
                    armed_next = 1'b1;
                end else if (armed) begin
                    state_next = START;
                    samp_next  = '0;
                    armed_next = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (samp_cnt == MID_CNT) begin
                        samp_next = '0;
                        if (!rx_s) begin
                            state_next = DATA;
                            bit_next   = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        samp_next = samp_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (samp_cnt == LAST_CNT) begin
                        samp_next  = '0;
                        shreg_next = {rx_s, shreg[DATA_BITS-1:1]};
                        bit_next   = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end
                    end else begin
                        samp_next = samp_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (samp_cnt == LAST_CNT) begin
                        samp_next  = '0;
                        par_next   = rx_s;
                        state_next = STOP;
                    end else begin
                        samp_next = samp_cnt + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (samp_cnt == LAST_CNT) begin
                        samp_next  = '0;
                        load       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        samp_next = samp_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            samp_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            armed    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            samp_cnt <= samp_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            armed    <= armed_next;
`ifdef UART_RX_PARITY_EN
            par_bit  <= par_next;
`endif
        end
    end

    // A load always wins over read_ack: an ack in the load cycle consumes the old
    // byte, so the new one stays pending and no overrun is flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data      <= '0;
            outValid     <= 1'b0;
            read_ready   <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error <= 1'b0;
`endif
        end else begin
            outValid <= load;
            if (load) begin
                rx_data     <= shreg;
                frame_error <= ~rx_s;
                read_ready  <= 1'b1;
                if (read_ready && !read_ack) begin
                    overrun <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                parity_error <= ^{shreg, par_bit};
`endif
            end else if (read_ack) begin
                read_ready <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule
